full_adder_unit: RTL and testbench
==================================

FULL_ADDER_UNIT -- requirements
Module: full_adder_unit

Interface
REQ-001 Parameter WIDTH, default 1: operand and sum width in bits, legal range 1..64.
REQ-002 One clock, clk; reset is asynchronous and active-low, rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  in1/in2/c0 are valid this cycle.
REQ-006 in1  input  WIDTH  operand A, unsigned.
REQ-007 in2  input  WIDTH  operand B, unsigned.
REQ-008 c0  input  1  carry-in.
REQ-009 out_valid  output  1  Sum/Carry hold a new result this cycle.
REQ-010 Sum  output  WIDTH  registered sum bits.
REQ-011 Carry  output  1  registered carry-out.

Function
REQ-012 On a rising clk edge with in_valid=1, the block SHALL register {Carry, Sum} = in1 + in2 + c0, computed at WIDTH+1 bits with no truncation of the carry.
REQ-013 For WIDTH=1: Sum = in1 XOR in2 XOR c0; Carry = majority(in1, in2, c0).
REQ-014 The latency SHALL be exactly 1 cycle: out_valid rises on the edge after in_valid is sampled high.
REQ-015 out_valid SHALL be a registered copy of in_valid, with no backpressure and no ready signal.
REQ-016 With in_valid=0, Sum and Carry SHALL hold their previous values, and out_valid SHALL fall to 0.
REQ-017 Back-to-back in_valid SHALL give one result per cycle, in order.
REQ-018 Wrap-around: all-ones + all-ones + 1 SHALL give Sum=all-ones and Carry=1.
REQ-019 The carry chain SHALL be a ripple of WIDTH 1-bit cells, with c0 feeding bit 0.

Reset
REQ-020 While rst_n=0, Sum, Carry and out_valid SHALL be 0, asynchronously and regardless of clk.
REQ-021 Reset asserted mid-stream SHALL discard any in-flight result; the first valid input after reset release SHALL be processed normally.
REQ-022 Reset deassertion SHALL be used synchronously to clk, with no output update on the release edge unless in_valid=1.

Configuration
REQ-023 Macro FULL_ADDER_OVF_EN: when defined, an extra output ovf (1 bit) SHALL be registered alongside Sum, equal to signed overflow (carry into MSB XOR carry out of MSB), and reset to 0.
REQ-024 When FULL_ADDER_OVF_EN is undefined, the ovf port and its logic SHALL be absent, and behaviour is otherwise identical.

Structure
REQ-025 Package full_adder_pkg SHALL hold the DEFAULT_WIDTH=1 and MAX_WIDTH=64 constants and a result struct type {carry, sum}.
REQ-026 Sub-module full_adder_bit SHALL be the combinational 1-bit cell (a, b, ci -> s, co), instantiated WIDTH times.
REQ-027 The top SHALL contain only the cell chain, the output registers, the valid register and an elaboration check on the WIDTH range.

Verification
REQ-028 WIDTH=1, all 8 combinations of (in1, in2, c0) with in_valid=1 -> Sum/Carry one cycle later equal 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1 in order 000..111.
REQ-029 WIDTH=8, in1=0xFF, in2=0x01, c0=0 -> Sum=0x00, Carry=1; with FULL_ADDER_OVF_EN defined, ovf=0.
REQ-030 WIDTH=8, in1=0x7F, in2=0x00, c0=1 -> Sum=0x80, Carry=0, ovf=1 (when enabled).
REQ-031 Drive in_valid high for 3 cycles, then low for 2 cycles -> out_valid is high for exactly 3 cycles, lagging by 1 cycle, and Sum holds the last result while out_valid=0.
REQ-032 Assert rst_n=0 between clock edges while a result is pending -> Sum, Carry and out_valid are 0 immediately; the first input after release yields a correct result 1 cycle later.
REQ-033 WIDTH=8, in1=0xFF, in2=0xFF, c0=1 -> Sum=0xFF, Carry=1.

Source files
------------

// File: rtl/full_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_pkg
//  Description : Shared constants and result type for the full_adder_unit
//                block: default and maximum operand width, plus a
//                {carry, sum} result record sized for the widest operand.
//  Revision    : 1.0  initial release
// ============================================================================
package full_adder_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int MAX_WIDTH     = 64;

    // Result of one addition. The sum field is sized for MAX_WIDTH; narrower
    // instances use only the low WIDTH bits.
    typedef struct packed {
        logic                 carry;
        logic [MAX_WIDTH-1:0] sum;
    } result_t;

endpackage
`default_nettype wire

// File: rtl/full_adder_bit.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_bit
//  Description : Combinational 1-bit full-adder cell.
//  Ports       : a, b  - operand bits
//                ci    - carry in
//                s     - sum bit   (a ^ b ^ ci)
//                co    - carry out (majority of a, b, ci)
//  Revision    : 1.0  initial release
// ============================================================================
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule
`default_nettype wire

// File: rtl/full_adder_unit.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_unit
//  Description : Registered WIDTH-bit ripple-carry adder. On each rising clk
//                edge with in_valid high, {Carry, Sum} = in1 + in2 + c0 is
//                captured; out_valid is in_valid delayed by one cycle. With
//                in_valid low the result registers hold their value.
//  Ports       : clk       - rising-edge clock
//                rst_n     - asynchronous active-low reset
//                in_valid  - operands valid this cycle
//                in1, in2  - unsigned operands, WIDTH bits
//                c0        - carry in
//                out_valid - Sum/Carry hold a new result
//                Sum       - registered sum, WIDTH bits
//                Carry     - registered carry out
//                ovf       - registered signed overflow (only when the
//                            FULL_ADDER_OVF_EN macro is defined)
//  Config      : FULL_ADDER_OVF_EN - adds the ovf output and its register.
//  Revision    : 1.0  initial release
// ============================================================================
module full_adder_unit
    import full_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c0,
    output logic             out_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
`ifdef FULL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("full_adder_unit: WIDTH=%0d outside legal range 1..%0d",
               WIDTH, MAX_WIDTH);
    end

    // Ripple chain: carry[i] feeds cell i, carry[WIDTH] is the carry out.
    logic [WIDTH:0]   carry_chain;
    logic [WIDTH-1:0] sum_d;

    assign carry_chain[0] = c0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_bit u_bit (
            .a  (in1[i]),
            .b  (in2[i]),
            .ci (carry_chain[i]),
            .s  (sum_d[i]),
            .co (carry_chain[i+1])
        );
    end

    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q   <= sum_d;
                carry_q <= carry_chain[WIDTH];
            end
        end
    end

    assign Sum       = sum_q;
    assign Carry     = carry_q;
    assign out_valid = valid_q;

`ifdef FULL_ADDER_OVF_EN
    // Signed overflow: carry into the MSB disagrees with carry out of it.
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = carry_chain[WIDTH] ^ carry_chain[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (in_valid) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_full_adder_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_full_adder_unit
//  Description : Self-checking bench for full_adder_unit. Drives a WIDTH=1
//                and a WIDTH=8 instance side by side and compares both to an
//                arithmetic reference model every cycle, plus fixed vector
//                tables and hand-written valid/reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_full_adder_unit;
    import full_adder_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // WIDTH=1 instance signals
    logic       v1_i, c1_i, a1_i, b1_i;
    logic       ov1_o, s1_o, co1_o;
    // WIDTH=8 instance signals
    logic       v8_i, c8_i;
    logic [7:0] a8_i, b8_i, s8_o;
    logic       ov8_o, co8_o;
`ifdef FULL_ADDER_OVF_EN
    logic       f1_o, f8_o;
`endif

    full_adder_unit #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1_i),
        .in1(a1_i), .in2(b1_i), .c0(c1_i),
        .out_valid(ov1_o), .Sum(s1_o), .Carry(co1_o)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(f1_o)
`endif
    );

    full_adder_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8_i),
        .in1(a8_i), .in2(b8_i), .c0(c8_i),
        .out_valid(ov8_o), .Sum(s8_o), .Carry(co8_o)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(f8_o)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint unsigned act,
                       input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    result_t m1, m8;
    logic    mv1, mv8, mf1, mf8;

    // Arithmetic view: add as integers, carry is bit WIDTH of the total,
    // overflow is the signed total falling outside the WIDTH-bit range.
    function automatic result_t add_ref(input longint unsigned a,
                                        input longint unsigned b,
                                        input logic c, input int w);
        result_t         r;
        longint unsigned t;
        t       = a + b + longint'(c);
        r.carry = t[w];
        r.sum   = MAX_WIDTH'(t & ((64'd1 << w) - 1));
        return r;
    endfunction

    function automatic logic ovf_ref(input longint unsigned a,
                                     input longint unsigned b,
                                     input logic c, input int w);
        longint sa, sb, t, lim;
        lim = longint'(1) << (w - 1);
        sa  = a[w-1] ? longint'(a) - (lim * 2) : longint'(a);
        sb  = b[w-1] ? longint'(b) - (lim * 2) : longint'(b);
        t   = sa + sb + longint'(c);
        return (t >= lim) || (t < -lim);
    endfunction

    task automatic model_reset();
        m1 = '0; m8 = '0; mv1 = 0; mv8 = 0; mf1 = 0; mf8 = 0;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, " v1"},  ov1_o, mv1);
        chk({tag, " s1"},  s1_o,  m1.sum[0]);
        chk({tag, " c1"},  co1_o, m1.carry);
        chk({tag, " v8"},  ov8_o, mv8);
        chk({tag, " s8"},  s8_o,  m8.sum[7:0]);
        chk({tag, " c8"},  co8_o, m8.carry);
`ifdef FULL_ADDER_OVF_EN
        chk({tag, " f1"},  f1_o,  mf1);
        chk({tag, " f8"},  f8_o,  mf8);
`endif
    endtask

    // One clock: model takes the current inputs, DUT clocks, then compare.
    task automatic tick(input string tag);
        if (rst_n) begin
            mv1 = v1_i;
            mv8 = v8_i;
            if (v1_i) begin
                m1  = add_ref(a1_i, b1_i, c1_i, 1);
                mf1 = ovf_ref(a1_i, b1_i, c1_i, 1);
            end
            if (v8_i) begin
                m8  = add_ref(a8_i, b8_i, c8_i, 8);
                mf8 = ovf_ref(a8_i, b8_i, c8_i, 8);
            end
        end
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        v1_i = 0; a1_i = 0; b1_i = 0; c1_i = 0;
        v8_i = 0; a8_i = 0; b8_i = 0; c8_i = 0;
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic [2:0] abc;
        logic       s, co;
    } vec1_t;

    typedef struct {
        logic [7:0] a, b;
        logic       c;
        logic [7:0] s;
        logic       co, ov;
    } vec8_t;

    vec1_t t1 [8];
    vec8_t t8 [5];

    initial begin
        int hi_cnt;
        logic [7:0] held;

        // {in1,in2,c0} = 000..111
        t1[0] = '{3'b000, 0, 0}; t1[1] = '{3'b001, 1, 0};
        t1[2] = '{3'b010, 1, 0}; t1[3] = '{3'b011, 0, 1};
        t1[4] = '{3'b100, 1, 0}; t1[5] = '{3'b101, 0, 1};
        t1[6] = '{3'b110, 0, 1}; t1[7] = '{3'b111, 1, 1};

        t8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        t8[1] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        t8[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        t8[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        t8[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

        // ---- reset state, asserted asynchronously before any clock edge
        idle_inputs();
        rst_n = 1;
        #1 rst_n = 0;
        #1;
        model_reset();
        compare_all("reset");
        tick("reset_clk");
        #2 rst_n = 1;               // release between edges
        tick("release_idle");       // no update on the release edge

        // ---- WIDTH=1 exhaustive table, back to back
        for (int i = 0; i < 8; i++) begin
            v1_i = 1;
            {a1_i, b1_i, c1_i} = t1[i].abc;
            tick("tbl1");
            chk($sformatf("tbl1[%0d] sum", i),   s1_o,  t1[i].s);
            chk($sformatf("tbl1[%0d] carry", i), co1_o, t1[i].co);
        end
        idle_inputs();
        tick("tbl1_end");

        // ---- WIDTH=8 boundary table
        for (int i = 0; i < 5; i++) begin
            v8_i = 1;
            a8_i = t8[i].a; b8_i = t8[i].b; c8_i = t8[i].c;
            tick("tbl8");
            chk($sformatf("tbl8[%0d] sum", i),   s8_o,  t8[i].s);
            chk($sformatf("tbl8[%0d] carry", i), co8_o, t8[i].co);
`ifdef FULL_ADDER_OVF_EN
            chk($sformatf("tbl8[%0d] ovf", i),   f8_o,  t8[i].ov);
`endif
        end
        idle_inputs();
        tick("tbl8_end");

        // ---- valid for 3 cycles, idle for 2: out_valid high exactly 3
        hi_cnt = 0;
        held   = 8'h00;
        for (int i = 0; i < 5; i++) begin
            v8_i = (i < 3);
            a8_i = 8'($urandom); b8_i = 8'($urandom); c8_i = 1'($urandom);
            if (i == 2) held = 8'(add_ref(a8_i, b8_i, c8_i, 8).sum);
            tick("vseq");
            if (ov8_o) hi_cnt++;
            if (i >= 3) chk("vseq hold sum", s8_o, held);
        end
        chk("vseq out_valid count", hi_cnt, 3);

        // ---- reset mid-stream with a result registered and one in flight
        v8_i = 1; a8_i = 8'hA5; b8_i = 8'h5A; c8_i = 1;   // 0x100 -> 00/1
        v1_i = 1; a1_i = 1; b1_i = 1; c1_i = 1;
        tick("pre_rst");
        a8_i = 8'h12; b8_i = 8'h34; c8_i = 0;
        #2 rst_n = 0;
        #1;
        model_reset();
        compare_all("mid_rst");
        chk("mid_rst carry8", co8_o, 0);
        #1 rst_n = 1;
        idle_inputs();
        tick("post_rst_idle");
        v8_i = 1; a8_i = 8'hC8; b8_i = 8'h64; c8_i = 1;  // 0x12D -> 2D/1
        tick("post_rst_first");
        chk("post_rst sum",   s8_o,  8'h2D);
        chk("post_rst carry", co8_o, 1);
        chk("post_rst valid", ov8_o, 1);

        // ---- randomized traffic on both instances
        for (int i = 0; i < 300; i++) begin
            v1_i = 1'($urandom); a1_i = 1'($urandom);
            b1_i = 1'($urandom); c1_i = 1'($urandom);
            v8_i = ($urandom_range(0, 3) != 0);
            a8_i = 8'($urandom); b8_i = 8'($urandom); c8_i = 1'($urandom);
            tick("rand");
        end
        idle_inputs();
        tick("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
